// File: rtl/lut4_init_extractor_if.sv
// Result handshake between a LUT truth-table reader and its client.
// The client (master) requests sweeps and accepts results; the extractor is the slave.
interface lut4_init_extractor_if;
    logic        start;
    logic        busy;
    logic [15:0] init;
    logic        out_valid;
    logic        out_ready;

    modport master (
        output start,
        output out_ready,
        input  busy,
        input  init,
        input  out_valid
    );

    modport slave (
        input  start,
        input  out_ready,
        output busy,
        output init,
        output out_valid
    );
endinterface

// File: rtl/lut4_init_extractor.sv
// Walks a 4-input LUT through all 16 input codes, samples its output after SETTLE
// cycles per code and returns the assembled INIT mask. SETTLE must be 1..15.
module lut4_init_extractor #(
    parameter int SETTLE = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    lut4_init_extractor_if.slave        hs,
    output logic [3:0]                  lut_i,
    input  logic                        lut_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE - 1);

    state_t      state_reg, state_next;
    logic [3:0]  idx_reg, idx_next;
    logic [3:0]  cnt_reg, cnt_next;
    logic [15:0] init_reg, init_next;
    logic        valid_reg, valid_next;
    logic        busy_reg, busy_next;
    logic [15:0] bit_sel;

    // One-hot select of the mask bit that belongs to the current input code.
    for (genvar gi = 0; gi < 16; gi++) begin : g_sel
        assign bit_sel[gi] = (idx_reg == 4'(gi));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            idx_reg   <= 4'h0;
            cnt_reg   <= 4'h0;
            init_reg  <= 16'h0000;
            valid_reg <= 1'b0;
            busy_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
            cnt_reg   <= cnt_next;
            init_reg  <= init_next;
            valid_reg <= valid_next;
            busy_reg  <= busy_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        cnt_next   = cnt_reg;
        init_next  = init_reg;
        valid_next = valid_reg;
        busy_next  = busy_reg;

        case (state_reg)
            IDLE: begin
                if (hs.start) begin
                    state_next = SWEEP;
                    idx_next   = 4'h0;
                    cnt_next   = SETTLE_LOAD;
                    init_next  = 16'h0000;
                    busy_next  = 1'b1;
                end
            end
            SWEEP: begin
                if (cnt_reg != 4'h0) begin
                    cnt_next = cnt_reg - 4'd1;
                end else begin
                    init_next = (init_reg & ~bit_sel) | ({16{lut_o}} & bit_sel);
                    if (idx_reg != 4'hF) begin
                        idx_next = idx_reg + 4'd1;
                        cnt_next = SETTLE_LOAD;
                    end else begin
                        // lut_i parks at 4'hF until the next sweep restarts it.
                        state_next = HOLD;
                        valid_next = 1'b1;
                        busy_next  = 1'b0;
                    end
                end
            end
            HOLD: begin
                if (hs.out_ready) begin
                    state_next = IDLE;
                    valid_next = 1'b0;
                end
            end
            default: begin
                state_next = IDLE;
                valid_next = 1'b0;
                busy_next  = 1'b0;
            end
        endcase
    end

    assign lut_i        = idx_reg;
    assign hs.init      = init_reg;
    assign hs.out_valid = valid_reg;
    assign hs.busy      = busy_reg;

endmodule

// File: tb/tb_lut4_init_extractor.sv
// Bench for lut4_init_extractor: three instances (SETTLE 1, 2, 3) driven by directed
// sweeps; a monitor pops expected masks from a queue whenever a result appears.
module tb_lut4_init_extractor;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [2:0]  start_v  = '0;
    logic [2:0]  ready_v  = '0;
    logic [2:0]  reg_mode = '0;
    logic [2:0]  busy_v;
    logic [2:0]  valid_v;
    logic [2:0]  lut_o_v;
    logic [3:0]  lut_i_a [3];
    logic [15:0] init_a  [3];
    logic [15:0] fmask   [3];

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    typedef struct {
        int          dut;
        logic [15:0] init;
    } exp_t;
    exp_t exp_q [$];

    // Instance gi has SETTLE = gi+1; its LUT model is a mask table or a registered XOR.
    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
        lut4_init_extractor_if hs ();
        logic lut_o_reg;

        assign hs.start     = start_v[gi];
        assign hs.out_ready = ready_v[gi];
        assign busy_v[gi]   = hs.busy;
        assign valid_v[gi]  = hs.out_valid;
        assign init_a[gi]   = hs.init;

        always @(posedge clk) lut_o_reg <= ^lut_i_a[gi];
        assign lut_o_v[gi] = reg_mode[gi] ? lut_o_reg : fmask[gi][lut_i_a[gi]];

        lut4_init_extractor #(.SETTLE(gi + 1)) u_dut (
            .clk   (clk),
            .rst   (rst),
            .hs    (hs.slave),
            .lut_i (lut_i_a[gi]),
            .lut_o (lut_o_v[gi])
        );
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard monitor: latency measured from busy rising to out_valid rising.
    initial begin
        logic [2:0] busy_p  = '0;
        logic [2:0] valid_p = '0;
        int         t0 [3]  = '{0, 0, 0};
        exp_t       e;
        forever begin
            @(negedge clk);
            for (int d = 0; d < 3; d++) begin
                if (busy_v[d] && !busy_p[d]) t0[d] = cyc;
                if (valid_v[d] && !valid_p[d]) begin
                    if (exp_q.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL unexpected_result: dut%0d init=%h, expected no result", d, init_a[d]);
                    end else begin
                        e = exp_q.pop_front();
                        check("result_dut", d, e.dut);
                        check("result_init", {16'h0, init_a[d]}, {16'h0, e.init});
                        check("result_latency", cyc - t0[d], 16 * (d + 1));
                        $display("result dut%0d init=%h latency=%0d", d, init_a[d], cyc - t0[d]);
                    end
                end
            end
            busy_p  = busy_v;
            valid_p = valid_v;
        end
    end

    // Called just after a negedge; returns at the negedge following the accepting edge.
    task automatic start_sweep(input int d, input logic [15:0] e);
        exp_t x;
        x.dut  = d;
        x.init = e;
        exp_q.push_back(x);
        start_v[d] = 1'b1;
        @(negedge clk);
        start_v[d] = 1'b0;
    endtask

    task automatic wait_valid(input int d);
        int n = 0;
        while (!valid_v[d] && n < 64) begin
            @(negedge clk);
            n++;
        end
        check("valid_timeout", {31'h0, valid_v[d]}, 32'h1);
    endtask

    initial begin
        fmask[0] = 16'h0;
        fmask[1] = 16'h0;
        fmask[2] = 16'h0;

        // Reset and idle
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (10) begin
            @(negedge clk);
            for (int d = 0; d < 3; d++)
                check("idle_outputs", {busy_v[d], valid_v[d], lut_i_a[d], init_a[d]}, 32'h0);
        end

        // Basic sweep, SETTLE=1
        fmask[0]   = 16'h9701;
        ready_v[0] = 1'b1;
        start_sweep(0, 16'h9701);
        for (int k = 0; k < 16; k++) begin
            check("lut_i_step", {28'h0, lut_i_a[0]}, k);
            check("busy_sweep", {31'h0, busy_v[0]}, 32'h1);
            @(negedge clk);
        end
        check("valid_at_16", {31'h0, valid_v[0]}, 32'h1);
        check("busy_fall", {31'h0, busy_v[0]}, 32'h0);
        @(negedge clk);
        check("valid_fall", {31'h0, valid_v[0]}, 32'h0);
        check("init_kept", {16'h0, init_a[0]}, 32'h9701);
        ready_v[0] = 1'b0;

        // Settle and stall, SETTLE=3, registered XOR model
        reg_mode[2] = 1'b1;
        start_sweep(2, 16'h6996);
        for (int j = 0; j < 48; j++) begin
            check("lut_i_hold3", {28'h0, lut_i_a[2]}, j / 3);
            @(negedge clk);
        end
        check("valid_at_48", {31'h0, valid_v[2]}, 32'h1);
        repeat (5) begin
            @(negedge clk);
            check("stall_valid", {31'h0, valid_v[2]}, 32'h1);
            check("stall_init", {16'h0, init_a[2]}, 32'h6996);
        end
        ready_v[2] = 1'b1;
        @(negedge clk);
        check("stall_release", {31'h0, valid_v[2]}, 32'h0);
        check("stall_init_kept", {16'h0, init_a[2]}, 32'h6996);
        ready_v[2]  = 1'b0;
        reg_mode[2] = 1'b0;

        // Ignored start, SETTLE=1
        fmask[0] = 16'h1E2D;
        start_sweep(0, 16'h1E2D);
        repeat (4) @(negedge clk);
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        wait_valid(0);
        start_v[0] = 1'b1;
        ready_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        ready_v[0] = 1'b0;
        check("hold_start_valid", {31'h0, valid_v[0]}, 32'h0);
        repeat (3) begin
            check("hold_start_busy", {31'h0, busy_v[0]}, 32'h0);
            @(negedge clk);
        end
        fmask[0]   = 16'hC3A5;
        ready_v[0] = 1'b1;
        start_sweep(0, 16'hC3A5);
        wait_valid(0);
        @(negedge clk);

        // Reset mid-sweep, SETTLE=2
        fmask[1]   = 16'h3C5A;
        ready_v[1] = 1'b1;
        start_sweep(1, 16'h3C5A);
        repeat (11) @(negedge clk);
        check("pre_rst_busy", {31'h0, busy_v[1]}, 32'h1);
        rst = 1'b1;
        #1;
        check("rst_async", {busy_v[1], valid_v[1], lut_i_a[1], init_a[1]}, 32'h0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        start_sweep(1, 16'h3C5A);
        wait_valid(1);
        @(negedge clk);

        // Constant functions
        fmask[0] = 16'hFFFF;
        start_sweep(0, 16'hFFFF);
        wait_valid(0);
        @(negedge clk);
        fmask[1] = 16'h0000;
        start_sweep(1, 16'h0000);
        wait_valid(1);
        @(negedge clk);

        repeat (3) @(negedge clk);
        check("pending_results", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/lut4_init_extractor.md
# lut4_init_extractor

Sequential truth-table reader for a 4-input LUT. On request it drives all 16 input combinations onto a LUT under test, samples the LUT's single output for each, and returns the assembled 16-bit INIT mask through a valid/ready handshake. It sits next to LUT instances in test and characterisation builds and recovers the function a LUT actually implements.

## Interface
- SETTLE, default 1: cycles each input code is held before O is sampled. Legal range 1..15; other values are a configuration error.
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  sweep request; accepted only in IDLE
- busy  out  1  high while a sweep is in progress (state SWEEP)
- lut_i  out  4  input code driven to the LUT under test
- lut_o  in  1  LUT output; synchronous to clk, valid SETTLE cycles after lut_i changes
- init  out  16  extracted mask; bit k = LUT output for lut_i == k
- out_valid  out  1  init holds a complete result
- out_ready  in  1  consumer accepts the result

## Operation
- Reset values (asynchronous, immediate): state IDLE, busy 0, lut_i 4'h0, init 16'h0000, out_valid 0, internal index 0, settle counter 0.
- IDLE:
  - start=1 -> go to SWEEP, index=0, lut_i=0, settle counter=SETTLE-1, init cleared to 0.
- SWEEP:
  - Counter >0: decrement; lut_i stable.
  - Counter ==0: init[index] <= lut_o.
    - Index <15: index+1, lut_i=index+1, counter=SETTLE-1.
    - Index ==15: go to HOLD, out_valid=1. lut_i stays 4'hF.
- HOLD:
  - init and out_valid stable.
  - out_valid & out_ready -> IDLE, out_valid=0. init keeps its value until the next accepted start clears it.
- start is ignored in SWEEP and HOLD, including the HOLD cycle where the handshake completes. It is not queued.
- out_ready is ignored outside HOLD.
- busy = (state == SWEEP).
- Index is 4 bits with no wrap-around: the sweep ends at 15, never returns to 0 mid-sweep.
- Only lut_o is sampled; lut_o is not filtered or synchronised (it is assumed to be in the clk domain).
- rst asserted mid-sweep or in HOLD aborts immediately to reset values; the partial mask is discarded.

## Timing
- Start accepted at edge E0: lut_i=0 from E0, busy=1 from E0.
- Code k is presented for exactly SETTLE cycles, from edge E0+k·SETTLE to E0+(k+1)·SETTLE.
- lut_o is sampled at edge E0+(k+1)·SETTLE.
- Last sample and out_valid=1 occur at edge E0+16·SETTLE; busy falls at that same edge.
- Latency start→out_valid: 16·SETTLE cycles. SETTLE=1 → 16; SETTLE=3 → 48.
- Result is presented for ≥1 cycle.
  - out_ready=1 on the first valid cycle → IDLE at the next edge.
  - Earliest next start accepted: one cycle later (edge E0+16·SETTLE+2).
- All outputs are registered; no combinational path from any input to any output.

## Test plan
- Reset and idle: hold rst 3 cycles, then release with start=0 for 10 cycles → busy=0, out_valid=0, lut_i=0, init=16'h0000 throughout.
- Basic sweep: SETTLE=1; model outputs 1 for I in {0,8,9,10,12,15}; pulse start, out_ready=1.
  - Required: lut_i steps 0..15, one per cycle.
  - out_valid rises exactly 16 cycles after start is accepted, with init=16'h9701.
  - out_valid falls next cycle.
- Settle and stall: SETTLE=3; model is a registered (1-cycle latency) XOR of I; out_ready=0 for 5 cycles after valid.
  - Required: each lut_i held 3 cycles; out_valid at 48 cycles; init=16'h6996.
  - init and out_valid stable for the 5 stall cycles, then drop after out_ready=1.
- Ignored start: SETTLE=1.
  - Pulse start at cycle 5 of a sweep → latency and result unchanged.
  - Pulse start together with out_ready in HOLD → return to IDLE, no new sweep.
  - A later start sweeps normally.
- Reset mid-operation: SETTLE=2; assert rst at cycle 11 of a sweep.
  - Required: all outputs at reset values in the same cycle, with no clock edge needed.
  - After release, a new start yields the full correct mask with normal latency.
- Constant functions: model constant 1, then constant 0 → init=16'hFFFF and 16'h0000 respectively, 16·SETTLE latency each.
